integral_stream_gen: RTL and testbench

Streaming integral-image generator for the face-detection pipeline. It accepts one grayscale frame as a raster pixel stream and produces each integral value ii(x,y) with its linear address for the integral-image memory read by the Haar cascade cores. It sits directly upstream of the integral/cascade stage and replaces file-based preloading with a live pixel feed. It also drives the frame-size and mode signals that the cascade stage consumes.

---
 rtl/integral_stream_gen_if.sv | 38 +++
 rtl/integral_stream_gen.sv | 152 +++++++++++++++
 tb/tb_integral_stream_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/integral_stream_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | integral_stream_gen_if                                               |
// | Pixel-in / integral-out handshake bundle plus frame control/status.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface integral_stream_gen_if #(
  parameter int PIX_W = 8,
  parameter int II_W  = 32
);
  logic             start;
  logic [31:0]      width;
  logic [31:0]      height;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             ii_valid;
  logic [II_W-1:0]  ii_data;
  logic [31:0]      ii_addr;
  logic             ii_ready;
  logic [31:0]      size;
  logic             mode;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, width, height, pix_valid, pix_data, ii_ready,
    input  pix_ready, ii_valid, ii_data, ii_addr, size, mode, busy, done, err
  );

  modport slave (
    input  start, width, height, pix_valid, pix_data, ii_ready,
    output pix_ready, ii_valid, ii_data, ii_addr, size, mode, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/integral_stream_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | integral_stream_gen                                                  |
// | Streams a raster frame in and emits ii(x,y) with its linear address. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module integral_stream_gen #(
  parameter int MAX_WIDTH = 256,
  parameter int PIX_W     = 8,
  parameter int II_W      = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  integral_stream_gen_if.slave bus
);
  localparam int c_XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_XW-1:0] r_x;
  logic [c_XW-1:0] r_xlast;
  logic [31:0]     r_y;
  logic [31:0]     r_ylast;
  logic [31:0]     r_addr;
  logic [31:0]     r_ii_addr;
  logic [31:0]     r_size;
  logic [II_W-1:0] r_row_acc;
  logic [II_W-1:0] r_ii_data;
  logic            r_ii_valid;
  logic            r_mode;
  logic            r_done;
  logic            r_err;
  logic [II_W-1:0] r_linebuf [MAX_WIDTH];

  logic            w_dims_ok;
  logic            w_start_ok;
  logic            w_start_bad;
  logic            w_pix_ready;
  logic            w_accept;
  logic            w_out_hs;
  logic            w_last;
  logic            w_frame_end;
  logic [II_W-1:0] w_s;
  logic [II_W-1:0] w_up;
  logic [II_W-1:0] w_sum;

  assign w_dims_ok   = (bus.width >= 32'd1) && (bus.width <= 32'(MAX_WIDTH)) && (bus.height >= 32'd1);
  assign w_start_ok  = (r_state == S_IDLE) && bus.start && w_dims_ok;
  assign w_start_bad = (r_state == S_IDLE) && bus.start && !w_dims_ok;
  assign w_pix_ready = (r_state == S_RUN) && (!r_ii_valid || bus.ii_ready);
  assign w_accept    = bus.pix_valid && w_pix_ready;
  assign w_out_hs    = r_ii_valid && bus.ii_ready;
  assign w_last      = (r_x == r_xlast) && (r_y == r_ylast);

  // Row 0 and column 0 mask stale accumulator / line-buffer contents.
  assign w_s   = ((r_x == '0) ? '0 : r_row_acc) + II_W'(bus.pix_data);
  assign w_up  = (r_y == 32'd0) ? '0 : r_linebuf[r_x];
  assign w_sum = w_s + w_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (w_out_hs) begin
          w_state_nxt = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x        <= '0;
      r_xlast    <= '0;
      r_y        <= '0;
      r_ylast    <= '0;
      r_addr     <= '0;
      r_ii_addr  <= '0;
      r_size     <= '0;
      r_row_acc  <= '0;
      r_ii_data  <= '0;
      r_ii_valid <= 1'b0;
      r_mode     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      r_err  <= w_start_bad;
      if (w_start_ok) begin
        r_xlast   <= c_XW'(bus.width - 32'd1);
        r_ylast   <= bus.height - 32'd1;
        r_size    <= bus.width * bus.height;
        r_x       <= '0;
        r_y       <= '0;
        r_addr    <= '0;
        r_row_acc <= '0;
        r_mode    <= 1'b1;
      end else if (w_frame_end) begin
        r_mode <= 1'b0;
      end
      if (w_accept) begin
        r_ii_data  <= w_sum;
        r_ii_addr  <= r_addr;
        r_ii_valid <= 1'b1;
        r_row_acc  <= w_s;
        r_addr     <= r_addr + 32'd1;
        if (r_x == r_xlast) begin
          r_x <= '0;
          r_y <= r_y + 32'd1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end else if (w_out_hs) begin
        r_ii_valid <= 1'b0;
      end
    end
  end

  // Read of r_linebuf[r_x] above sees the previous row before this write lands.
  always_ff @(posedge clk) begin
    if (w_accept) r_linebuf[r_x] <= w_sum;
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.ii_valid  = r_ii_valid;
  assign bus.ii_data   = r_ii_data;
  assign bus.ii_addr   = r_ii_addr;
  assign bus.size      = r_size;
  assign bus.mode      = r_mode;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_integral_stream_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_integral_stream_gen                                               |
// | Directed frames checked against a summed-area reference model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_integral_stream_gen;
  logic clk;
  logic reset;
  logic toggle_en;
  int   checks;
  int   failures;
  int   err_count;

  int unsigned pixq[$];
  int unsigned exp_data[$];
  int unsigned exp_addr[$];
  bit          exp_last[$];
  int unsigned obs_data[$];
  int unsigned obs_addr[$];

  bit          holding;
  bit          expect_done;
  int unsigned held_data;
  int unsigned held_addr;

  integral_stream_gen_if #(.PIX_W(8), .II_W(32)) itf ();

  integral_stream_gen #(.MAX_WIDTH(256), .PIX_W(8), .II_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (itf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ii(x,y) is the plain sum of every pixel above-left of and including (x,y).
  task automatic build_model(input int w, input int h);
    int unsigned acc;
    exp_data.delete(); exp_addr.delete(); exp_last.delete();
    obs_data.delete(); obs_addr.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        acc = 0;
        for (int j = 0; j <= y; j++)
          for (int i = 0; i <= x; i++)
            acc += pixq[j*w+i];
        exp_data.push_back(acc);
        exp_addr.push_back(y*w+x);
        exp_last.push_back((x == w-1) && (y == h-1));
      end
    end
  endtask

  task automatic fill_const(input int n, input int unsigned v);
    pixq.delete();
    for (int i = 0; i < n; i++) pixq.push_back(v);
  endtask

  task automatic pulse_start(input int w, input int h);
    itf.width  = w;
    itf.height = h;
    itf.start  = 1'b1;
    @(posedge clk); #1;
    itf.start  = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi);
    bit got;
    int cyc;
    for (int i = lo; i < hi; i++) begin
      itf.pix_valid = 1'b1;
      itf.pix_data  = 8'(pixq[i]);
      got = 0;
      cyc = 0;
      while (!got && cyc < 64) begin
        @(negedge clk);
        if (itf.pix_ready) got = 1;
        else cyc++;
      end
      if (!got) begin
        chk("pix_accept_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    itf.pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (itf.done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (itf.done !== 1'b1) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("outputs_drained", exp_data.size(), 0);
  endtask

  task automatic run_frame(input int w, input int h);
    build_model(w, h);
    pulse_start(w, h);
    chk("busy_in_frame", itf.busy, 1);
    chk("mode_in_frame", itf.mode, 1);
    feed(0, w*h);
    wait_done();
  endtask

  always @(negedge clk) if (!reset && itf.err) err_count++;

  initial forever begin
    @(posedge clk); #1;
    if (toggle_en) itf.ii_ready = !itf.ii_ready;
  end

  // Every cycle: done timing, output hold under stall, and model comparison.
  always @(negedge clk) begin
    if (reset) begin
      holding     = 0;
      expect_done = 0;
    end else begin
      chk("done_pulse", itf.done, expect_done);
      if (expect_done) begin
        chk("mode_low_at_done", itf.mode, 0);
        chk("busy_low_at_done", itf.busy, 0);
      end
      expect_done = 0;
      if (holding) begin
        chk("hold_valid", itf.ii_valid, 1);
        chk("hold_data", itf.ii_data, held_data);
        chk("hold_addr", itf.ii_addr, held_addr);
      end
      holding = 0;
      if (itf.ii_valid) begin
        if (!itf.ii_ready) begin
          holding   = 1;
          held_data = itf.ii_data;
          held_addr = itf.ii_addr;
          chk("stall_pix_ready", itf.pix_ready, 0);
        end else if (exp_data.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("ii_data", itf.ii_data, exp_data[0]);
          chk("ii_addr", itf.ii_addr, exp_addr[0]);
          obs_data.push_back(itf.ii_data);
          obs_addr.push_back(itf.ii_addr);
          expect_done = exp_last[0];
          void'(exp_data.pop_front());
          void'(exp_addr.pop_front());
          void'(exp_last.pop_front());
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; err_count = 0;
    holding = 0; expect_done = 0; toggle_en = 0;
    reset = 1'b1;
    itf.start = 1'b0; itf.width = 0; itf.height = 0;
    itf.pix_valid = 1'b0; itf.pix_data = 0; itf.ii_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", itf.pix_ready, 0);
    chk("rst_ii_valid", itf.ii_valid, 0);
    chk("rst_ii_data", itf.ii_data, 0);
    chk("rst_ii_addr", itf.ii_addr, 0);
    chk("rst_size", itf.size, 0);
    chk("rst_flags", {itf.mode, itf.busy, itf.done, itf.err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 3x2 of ones
    fill_const(6, 1);
    run_frame(3, 2);
    chk("t1_size", itf.size, 6);
    chk("t1_count", obs_data.size(), 6);
    if (obs_data.size() == 6) begin
      chk("t1_d0", obs_data[0], 1); chk("t1_d1", obs_data[1], 2);
      chk("t1_d2", obs_data[2], 3); chk("t1_d3", obs_data[3], 2);
      chk("t1_d4", obs_data[4], 4); chk("t1_d5", obs_data[5], 6);
      chk("t1_a5", obs_addr[5], 5);
    end

    // 2x2 with output backpressure toggling
    pixq.delete();
    pixq.push_back(1); pixq.push_back(2); pixq.push_back(3); pixq.push_back(4);
    toggle_en = 1;
    run_frame(2, 2);
    toggle_en = 0;
    itf.ii_ready = 1'b1;
    chk("t2_count", obs_data.size(), 4);
    if (obs_data.size() == 4) begin
      chk("t2_d0", obs_data[0], 1); chk("t2_d1", obs_data[1], 3);
      chk("t2_d2", obs_data[2], 4); chk("t2_d3", obs_data[3], 10);
    end

    // widest frame, saturated pixels
    fill_const(512, 255);
    run_frame(256, 2);
    chk("t3_size", itf.size, 512);
    chk("t3_count", obs_data.size(), 512);
    if (obs_data.size() == 512) begin
      chk("t3_row0_end", obs_data[255], 65280);
      chk("t3_last_data", obs_data[511], 130560);
      chk("t3_last_addr", obs_addr[511], 511);
    end

    // invalid dimensions
    err_count = 0;
    pulse_start(0, 2);   @(posedge clk); #1;
    pulse_start(300, 2); @(posedge clk); #1;
    pulse_start(3, 0);   @(posedge clk); #1;
    chk("t4_err_cycles", err_count, 3);
    chk("t4_busy", itf.busy, 0);
    chk("t4_size_kept", itf.size, 512);

    // abort a 3x3 frame after 4 pixels, then a clean 3x3 of twos
    pixq.delete();
    for (int i = 0; i < 9; i++) pixq.push_back(9 - i);
    build_model(3, 3);
    pulse_start(3, 3);
    feed(0, 4);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_data.delete(); exp_addr.delete(); exp_last.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rst_busy", itf.busy, 0);
    chk("t5_rst_valid", itf.ii_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    fill_const(9, 2);
    run_frame(3, 3);
    chk("t5_count", obs_data.size(), 9);
    if (obs_data.size() == 9) begin
      chk("t5_d0", obs_data[0], 2); chk("t5_d1", obs_data[1], 4);
      chk("t5_d2", obs_data[2], 6); chk("t5_d4", obs_data[4], 8);
      chk("t5_d8", obs_data[8], 18);
    end

    // start pulsed mid-frame is ignored
    pixq.delete();
    for (int i = 1; i <= 6; i++) pixq.push_back(i);
    build_model(3, 2);
    pulse_start(3, 2);
    feed(0, 3);
    pulse_start(5, 7);
    chk("t6_size_kept", itf.size, 6);
    chk("t6_busy", itf.busy, 1);
    feed(3, 6);
    wait_done();
    chk("t6_count", obs_data.size(), 6);
    if (obs_data.size() == 6) begin
      chk("t6_d3", obs_data[3], 5);
      chk("t6_d5", obs_data[5], 21);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
